// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, scoring limit, paddle rows,
// the game FSM state encoding and a saturating score helper.
// No ports (package).
package pong_pkg;

    localparam int unsigned LCD_WIDTH  = 240;
    localparam int unsigned LCD_HEIGHT = 320;
    localparam int unsigned MAX_SCORE  = 10;
    localparam int unsigned PADDLE_1_Y = 20;   // player 1 paddle, top goal
    localparam int unsigned PADDLE_2_Y = 290;  // player 2 paddle, bottom goal

    // Codes are visible to Graphics through game_state, so keep them fixed.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    // Add one point, holding at the winning score instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] value,
                                           input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector.
// Ports: clock, reset (sync, active-high), in (level), pulse (one clock per
// rising edge of in).
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic armed;

    // armed stays low for the first clock after reset so a level that was
    // already high during reset is not mistaken for a fresh edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            in_q  <= in;
            armed <= 1'b1;
        end
    end

    assign pulse = in & ~in_q & armed;

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper and game sequencer.
// Ports: clock, reset (sync, active-high), tick (game-rate strobe),
// start (button level), ball_y (ball row) in; score_1, score_2,
// ball_reset (serve recentre pulse), ball_enable, serve_dir
// (0 up / 1 down), winner (0 none, 1 p1, 2 p2), game_state (FSM code) out.
module score_keeper #(
    parameter int unsigned LCD_HEIGHT  = pong_pkg::LCD_HEIGHT,
    parameter int unsigned MAX_SCORE   = pong_pkg::MAX_SCORE,
    parameter int unsigned SERVE_DELAY = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [8:0] ball_y,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic       ball_reset,
    output logic       ball_enable,
    output logic       serve_dir,
    output logic [1:0] winner,
    output logic [2:0] game_state
);

    import pong_pkg::*;

    localparam logic [3:0] SCORE_LIMIT = 4'(MAX_SCORE);
    localparam logic [7:0] SERVE_LAST  = 8'(SERVE_DELAY - 1);
    localparam logic [8:0] BOTTOM_ROW  = 9'(LCD_HEIGHT - 1);

    state_t     state, state_next;
    logic       start_edge;
    logic [7:0] counter, counter_next;
    logic       point_p2, point_p2_next;   // who scored the pending point
    logic [3:0] score_1_next, score_2_next;
    logic       ball_reset_next, ball_enable_next, serve_dir_next;
    logic [1:0] winner_next;

    rise_detect u_start_edge (
        .clock (clock),
        .reset (reset),
        .in    (start),
        .pulse (start_edge)
    );

    assign game_state = state;

    // Registered outputs are computed as next values so each one reflects
    // the state being entered on the same edge.
    always_comb begin
        state_next       = state;
        counter_next     = counter;
        point_p2_next    = point_p2;
        score_1_next     = score_1;
        score_2_next     = score_2;
        ball_reset_next  = 1'b0;
        ball_enable_next = 1'b0;
        serve_dir_next   = serve_dir;
        winner_next      = winner;

        case (state)
            IDLE, GAME_OVER: begin
                if (start_edge) begin
                    state_next      = SERVE;
                    score_1_next    = '0;
                    score_2_next    = '0;
                    winner_next     = '0;
                    serve_dir_next  = 1'b0;
                    counter_next    = '0;
                    ball_reset_next = 1'b1;
                end
            end
            SERVE: begin
                if (tick) begin
                    if (counter == SERVE_LAST) begin
                        state_next       = PLAY;
                        ball_enable_next = 1'b1;
                    end else begin
                        counter_next = counter + 8'd1;
                    end
                end
            end
            PLAY: begin
                ball_enable_next = 1'b1;
                if (tick) begin
                    if (ball_y == '0) begin
                        state_next       = POINT;
                        ball_enable_next = 1'b0;
                        point_p2_next    = 1'b1;
                        score_2_next     = sat_inc(score_2, SCORE_LIMIT);
                    end else if (ball_y >= BOTTOM_ROW) begin
                        state_next       = POINT;
                        ball_enable_next = 1'b0;
                        point_p2_next    = 1'b0;
                        score_1_next     = sat_inc(score_1, SCORE_LIMIT);
                    end
                end
            end
            POINT: begin
                if ((point_p2 ? score_2 : score_1) == SCORE_LIMIT) begin
                    state_next  = GAME_OVER;
                    winner_next = point_p2 ? 2'd2 : 2'd1;
                end else begin
                    // Serve toward whoever conceded.
                    state_next      = SERVE;
                    serve_dir_next  = ~point_p2;
                    counter_next    = '0;
                    ball_reset_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            point_p2    <= 1'b0;
            score_1     <= '0;
            score_2     <= '0;
            ball_reset  <= 1'b0;
            ball_enable <= 1'b0;
            serve_dir   <= 1'b0;
            winner      <= '0;
        end else begin
            state       <= state_next;
            counter     <= counter_next;
            point_p2    <= point_p2_next;
            score_1     <= score_1_next;
            score_2     <= score_2_next;
            ball_reset  <= ball_reset_next;
            ball_enable <= ball_enable_next;
            serve_dir   <= serve_dir_next;
            winner      <= winner_next;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with SERVE_DELAY=3, MAX_SCORE=2.
// Each table row is one clock: inputs driven at the falling edge, outputs
// compared 1 ns after the following rising edge.
module tb_score_keeper;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic       start = 1'b0;
    logic [8:0] ball_y = 9'd100;
    logic [3:0] score_1, score_2;
    logic       ball_reset, ball_enable, serve_dir;
    logic [1:0] winner;
    logic [2:0] game_state;

    int errors = 0;
    int checks = 0;

    score_keeper #(
        .LCD_HEIGHT  (320),
        .MAX_SCORE   (2),
        .SERVE_DELAY (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .ball_y      (ball_y),
        .score_1     (score_1),
        .score_2     (score_2),
        .ball_reset  (ball_reset),
        .ball_enable (ball_enable),
        .serve_dir   (serve_dir),
        .winner      (winner),
        .game_state  (game_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst, st, tk;
        logic [8:0] by;
        logic [2:0] gs;
        logic [3:0] s1, s2;
        logic       br, be, sd;
        logic [1:0] win;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(logic rst, logic st, logic tk, int by,
                                int gs, int s1, int s2, logic br, logic be,
                                logic sd, int win);
        vec_t v;
        v.rst = rst; v.st = st; v.tk = tk; v.by = 9'(by);
        v.gs = 3'(gs); v.s1 = 4'(s1); v.s2 = 4'(s2);
        v.br = br; v.be = be; v.sd = sd; v.win = 2'(win);
        return v;
    endfunction

    task automatic chk(input string name, input string tag, input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic tk,
                        input int by);
        @(negedge clock);
        reset = rst; start = st; tick = tk; ball_y = 9'(by);
        @(posedge clock);
        #1;
    endtask

    task automatic expect_outs(input string tag, input int gs, input int s1,
                               input int s2, input int br, input int be,
                               input int sd, input int win);
        chk("game_state",  tag, int'(game_state),  gs);
        chk("score_1",     tag, int'(score_1),     s1);
        chk("score_2",     tag, int'(score_2),     s2);
        chk("ball_reset",  tag, int'(ball_reset),  br);
        chk("ball_enable", tag, int'(ball_enable), be);
        chk("serve_dir",   tag, int'(serve_dir),   sd);
        chk("winner",      tag, int'(winner),      win);
    endtask

    initial begin
        //            rst st tk  by   gs s1 s2 br be sd win
        tbl[0]  = mk(1, 0, 0, 100, 0, 0, 0, 0, 0, 0, 0); // reset
        tbl[1]  = mk(0, 0, 0, 100, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 100, 1, 0, 0, 1, 0, 0, 0); // start; tick not counted
        tbl[3]  = mk(0, 1, 1, 100, 1, 0, 0, 0, 0, 0, 0); // tick 1
        tbl[4]  = mk(0, 1, 0, 100, 1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 100, 1, 0, 0, 0, 0, 0, 0); // tick 2
        tbl[6]  = mk(0, 0, 1, 100, 2, 0, 0, 0, 1, 0, 0); // tick 3 -> PLAY
        tbl[7]  = mk(0, 0, 0,   0, 2, 0, 0, 0, 1, 0, 0); // top, no tick
        tbl[8]  = mk(0, 0, 1,   0, 3, 0, 1, 0, 0, 0, 0); // p2 scores
        tbl[9]  = mk(0, 0, 0, 100, 1, 0, 1, 1, 0, 0, 0); // serve up
        tbl[10] = mk(0, 0, 1, 100, 1, 0, 1, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 100, 1, 0, 1, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, 100, 2, 0, 1, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 319, 2, 0, 1, 0, 1, 0, 0); // bottom, no tick
        tbl[14] = mk(0, 0, 1, 319, 3, 1, 1, 0, 0, 0, 0); // p1 scores
        tbl[15] = mk(0, 0, 0, 100, 1, 1, 1, 1, 0, 1, 0); // serve down
        tbl[16] = mk(0, 1, 1, 100, 1, 1, 1, 0, 0, 1, 0); // start ignored
        tbl[17] = mk(0, 0, 1, 100, 1, 1, 1, 0, 0, 1, 0);
        tbl[18] = mk(0, 0, 1, 100, 2, 1, 1, 0, 1, 1, 0);
        tbl[19] = mk(0, 0, 1, 319, 3, 2, 1, 0, 0, 1, 0); // p1 reaches 2
        tbl[20] = mk(0, 0, 0, 319, 4, 2, 1, 0, 0, 1, 1); // GAME_OVER
        tbl[21] = mk(0, 0, 1, 319, 4, 2, 1, 0, 0, 1, 1); // held
        tbl[22] = mk(0, 0, 1,   0, 4, 2, 1, 0, 0, 1, 1);
        tbl[23] = mk(0, 1, 0, 100, 1, 0, 0, 1, 0, 0, 0); // restart
        tbl[24] = mk(0, 1, 0, 100, 1, 0, 0, 0, 0, 0, 0);
        tbl[25] = mk(1, 1, 0, 100, 0, 0, 0, 0, 0, 0, 0); // reset mid-SERVE
        tbl[26] = mk(0, 1, 0, 100, 0, 0, 0, 0, 0, 0, 0); // held start: no edge
        tbl[27] = mk(0, 1, 0, 100, 0, 0, 0, 0, 0, 0, 0);
        tbl[28] = mk(0, 0, 0, 100, 0, 0, 0, 0, 0, 0, 0);
        tbl[29] = mk(0, 1, 0, 100, 1, 0, 0, 1, 0, 0, 0); // fresh edge

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].tk, int'(tbl[i].by));
            expect_outs($sformatf("row%0d", i), int'(tbl[i].gs),
                        int'(tbl[i].s1), int'(tbl[i].s2), int'(tbl[i].br),
                        int'(tbl[i].be), int'(tbl[i].sd), int'(tbl[i].win));
        end

        // Bottom-row boundary, overshoot, then reset mid-PLAY.
        step(0, 0, 1, 100); expect_outs("srv1", 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 100); expect_outs("srv2", 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 100); expect_outs("play", 2, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 318); expect_outs("row318", 2, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 400); expect_outs("row400", 3, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 100); expect_outs("resrv", 1, 1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 100); expect_outs("resrv1", 1, 1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 100); expect_outs("resrv2", 1, 1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 100); expect_outs("replay", 2, 1, 0, 0, 1, 1, 0);
        step(1, 0, 1,   0); expect_outs("rst_play", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1,   0); expect_outs("idle_after", 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
